// File: rtl/block_stat_if.sv
// block_stat_if -- pixel-in / statistic-out bundle for block_stat.
//   vs, de, gray, mode : frame sync, pixel qualifier, luminance, statistic select
//   out_ready          : downstream accepts a statistic this cycle
//   stat, stat_valid, stat_bx, stat_by : block statistic and its block indices
//   frame_done, ovf    : end-of-frame pulse, sticky dropped-row flag
// master drives pixels and out_ready; slave (block_stat) drives the statistics.
interface block_stat_if #(
  parameter int DW = 8
);
  logic          vs;
  logic          de;
  logic [DW-1:0] gray;
  logic [1:0]    mode;
  logic          out_ready;
  logic [DW-1:0] stat;
  logic          stat_valid;
  logic [5:0]    stat_bx;
  logic [5:0]    stat_by;
  logic          frame_done;
  logic          ovf;

  modport master (
    output vs, de, gray, mode, out_ready,
    input  stat, stat_valid, stat_bx, stat_by, frame_done, ovf
  );

  modport slave (
    input  vs, de, gray, mode, out_ready,
    output stat, stat_valid, stat_bx, stat_by, frame_done, ovf
  );
endinterface

// File: rtl/block_stat.sv
// block_stat -- per-block luminance statistics (mean / max / blend) over a
// grid of NBX x NBY blocks of BLK_W x BLK_H pixels, drained one block column
// at a time through a valid/ready output.
//   clk  : rising-edge clock
//   rstn : asynchronous active-low reset
//   bus  : block_stat_if slave (pixel input, statistic output, frame_done, ovf)
module block_stat #(
  parameter int DW    = 8,
  parameter int BLK_W = 32,
  parameter int BLK_H = 32,
  parameter int NBX   = 40,
  parameter int NBY   = 20
) (
  input  logic         clk,
  input  logic         rstn,
  block_stat_if.slave  bus
);

  localparam int LW  = $clog2(BLK_W);
  localparam int LH  = $clog2(BLK_H);
  localparam int SH  = LW + LH;
  localparam int SW  = DW + SH;
  localparam int PXW = $clog2(NBX * BLK_W) + 1;
  localparam int LNW = $clog2(NBY * BLK_H) + 1;
  localparam int BXW = PXW - LW;
  localparam int IW  = (NBX > 1) ? $clog2(NBX) : 1;

  localparam logic [PXW-1:0] PX_LIM   = PXW'(NBX * BLK_W);
  localparam logic [LNW-1:0] LN_LIM   = LNW'(NBY * BLK_H);
  localparam logic [IW-1:0]  LAST_IDX = IW'(NBX - 1);
  localparam logic [5:0]     LAST_ROW = 6'(NBY - 1);

  typedef enum logic {IDLE, DRAIN} state_t;

  state_t         state_q;
  logic           vs_q, de_q, active_q;
  logic [1:0]     mode_q;
  logic [PXW-1:0] px_q;
  logic [LNW-1:0] ln_q;
  logic [SW-1:0]  sum_q    [NBX];
  logic [DW-1:0]  max_q    [NBX];
  logic [DW-1:0]  shadow_q [NBX];
  logic [DW-1:0]  res      [NBX];
  logic [IW-1:0]  idx_q;
  logic [DW-1:0]  stat_q;
  logic           stat_valid_q;
  logic [5:0]     by_q;
  logic           frame_done_q;
  logic           ovf_q;

  logic           vs_rise, de_fall, pix_ok, row_done;
  logic           accept, final_acc, load;
  logic [BXW-1:0] bx;
  logic [LW-1:0]  xl;
  logic [LH-1:0]  yl;
  logic [5:0]     by_cur;

  assign vs_rise = bus.vs & ~vs_q;
  assign de_fall = de_q & ~bus.de;
  assign bx      = px_q[PXW-1:LW];
  assign xl      = px_q[LW-1:0];
  assign yl      = ln_q[LH-1:0];
  assign by_cur  = 6'(ln_q >> LH);

  // active_q gates everything so that a reset mid-frame stays silent until
  // the next vs rise re-aligns the line counter.
  assign pix_ok   = active_q & bus.de & (px_q < PX_LIM) & (ln_q < LN_LIM);
  assign row_done = active_q & de_fall & ~vs_rise & (ln_q < LN_LIM) & (yl == '1);

  assign accept    = stat_valid_q & bus.out_ready;
  assign final_acc = accept & (idx_q == LAST_IDX);
  // A row finishing on the same cycle as the last acceptance is taken, not dropped.
  assign load      = row_done & ((state_q == IDLE) | final_acc);

  always_comb begin
    for (int unsigned c = 0; c < NBX; c++) begin
      res[c] = sum_q[c][SW-1:SH];
      case (mode_q)
        2'd1:    res[c] = max_q[c];
        2'd2:    res[c] = DW'(({1'b0, sum_q[c][SW-1:SH]} + {1'b0, max_q[c]}) >> 1);
        default: res[c] = sum_q[c][SW-1:SH];
      endcase
    end
  end

  // Per-column accumulation; first pixel of in-block line 0 restarts the block.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int unsigned c = 0; c < NBX; c++) begin
        sum_q[c] <= '0;
        max_q[c] <= '0;
      end
    end else if (pix_ok) begin
      for (int unsigned c = 0; c < NBX; c++) begin
        if (bx == BXW'(c)) begin
          if (yl == '0 && xl == '0) begin
            sum_q[c] <= SW'(bus.gray);
            max_q[c] <= bus.gray;
          end else begin
            sum_q[c] <= sum_q[c] + SW'(bus.gray);
            if (bus.gray > max_q[c]) max_q[c] <= bus.gray;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int unsigned c = 0; c < NBX; c++) shadow_q[c] <= '0;
    end else if (load) begin
      for (int unsigned c = 0; c < NBX; c++) shadow_q[c] <= res[c];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= IDLE;
      vs_q         <= 1'b0;
      de_q         <= 1'b0;
      active_q     <= 1'b0;
      mode_q       <= '0;
      px_q         <= '0;
      ln_q         <= '0;
      idx_q        <= '0;
      stat_q       <= '0;
      stat_valid_q <= 1'b0;
      by_q         <= '0;
      frame_done_q <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      vs_q         <= bus.vs;
      de_q         <= bus.de;
      frame_done_q <= 1'b0;

      // Counters saturate so over-long lines/frames never wrap into range.
      if (bus.de) begin
        if (px_q != '1) px_q <= px_q + 1'b1;
      end else if (de_fall) begin
        px_q <= '0;
      end
      if (vs_rise) ln_q <= '0;
      else if (de_fall && ln_q != '1) ln_q <= ln_q + 1'b1;

      if (vs_rise) begin
        active_q     <= 1'b1;
        mode_q       <= bus.mode;
        ovf_q        <= 1'b0;
        state_q      <= IDLE;
        stat_valid_q <= 1'b0;
      end else begin
        if (row_done && state_q == DRAIN && !final_acc) ovf_q <= 1'b1;
        if (final_acc && by_q == LAST_ROW) frame_done_q <= 1'b1;
        if (load) begin
          state_q      <= DRAIN;
          stat_valid_q <= 1'b1;
          idx_q        <= '0;
          stat_q       <= res[0];
          by_q         <= by_cur;
        end else if (final_acc) begin
          state_q      <= IDLE;
          stat_valid_q <= 1'b0;
        end else if (accept) begin
          idx_q  <= idx_q + 1'b1;
          stat_q <= shadow_q[idx_q + 1'b1];
        end
      end
    end
  end

  assign bus.stat       = stat_q;
  assign bus.stat_valid = stat_valid_q;
  assign bus.stat_bx    = 6'(idx_q);
  assign bus.stat_by    = by_q;
  assign bus.frame_done = frame_done_q;
  assign bus.ovf        = ovf_q;

endmodule

// File: tb/tb_block_stat.sv
// tb_block_stat -- randomized self-checking bench for block_stat
// (DW=8, 4x4 blocks, 3x2 grid). Expected statistics come from a frame image
// held in the bench and reduced per block with plain arithmetic.
module tb_block_stat;

  localparam int DW  = 8;
  localparam int BW  = 4;
  localparam int BH  = 4;
  localparam int NX  = 3;
  localparam int NY  = 2;
  localparam int LPX = NX * BW + 2;   // two ignored pixels per line
  localparam int NLN = NY * BH + 1;   // one ignored line per frame
  localparam int GAP = 4;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  block_stat_if #(.DW(DW)) bus ();

  block_stat #(.DW(DW), .BLK_W(BW), .BLK_H(BH), .NBX(NX), .NBY(NY)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  typedef struct {int stat; int bx; int by;} exp_t;
  exp_t q[$];
  int   img [NLN][LPX];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   fd_cnt = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Output monitor: in-order scoreboard on accepted statistics plus a
  // hold-stable check whenever an offered statistic was not taken.
  initial begin
    logic       prev_v = 1'b0, prev_r = 1'b0;
    logic [7:0] prev_s = '0;
    logic [5:0] prev_bx = '0, prev_by = '0;
    exp_t       e;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        prev_v = 1'b0;
      end else begin
        if (bus.frame_done) fd_cnt++;
        if (prev_v && !prev_r && bus.stat_valid) begin
          check("hold_stat", bus.stat, prev_s);
          check("hold_bx", bus.stat_bx, prev_bx);
          check("hold_by", bus.stat_by, prev_by);
        end
        if (bus.stat_valid && bus.out_ready) begin
          check("stat_expected", int'(q.size() != 0), 1);
          if (q.size() != 0) begin
            e = q.pop_front();
            check("stat", bus.stat, e.stat);
            check("stat_bx", bus.stat_bx, e.bx);
            check("stat_by", bus.stat_by, e.by);
          end
        end
        prev_v  = bus.stat_valid;
        prev_r  = bus.out_ready;
        prev_s  = bus.stat;
        prev_bx = bus.stat_bx;
        prev_by = bus.stat_by;
      end
    end
  end

  task automatic gen_img(input int pat);
    for (int r = 0; r < NLN; r++)
      for (int c = 0; c < LPX; c++) begin
        if (r >= NY * BH || c >= NX * BW) img[r][c] = $urandom_range(0, 255);
        else case (pat)
          0:       img[r][c] = 100;
          1:       img[r][c] = (r == 1 && c == 5) ? 250 : 10;
          2:       img[r][c] = 255;
          default: img[r][c] = $urandom_range(0, 255);
        endcase
      end
  endtask

  // Reference: mean = floor(sum/N), max, blend = floor((mean+max)/2); mode 3 = mean.
  task automatic push_exp(input int md, input int mask);
    exp_t e;
    for (int by = 0; by < NY; by++) begin
      if (((mask >> by) & 1) == 0) continue;
      for (int bx = 0; bx < NX; bx++) begin
        int sum = 0, mx = 0, mean;
        for (int y = 0; y < BH; y++)
          for (int x = 0; x < BW; x++) begin
            sum += img[by*BH+y][bx*BW+x];
            if (img[by*BH+y][bx*BW+x] > mx) mx = img[by*BH+y][bx*BW+x];
          end
        mean = sum / (BW * BH);
        e.stat = (md == 1) ? mx : (md == 2) ? (mean + mx) / 2 : mean;
        e.bx = bx;
        e.by = by;
        q.push_back(e);
      end
    end
  endtask

  task automatic vs_pulse(input int md);
    bus.mode = 2'(md);
    bus.vs   = 1'b1;
    tick();
    bus.vs   = 1'b0;
    bus.mode = 2'($urandom_range(0, 3));   // mode must be held from the vs sample
    repeat (3) tick();
  endtask

  task automatic drive_lines(input int r0, input int n);
    for (int r = r0; r < r0 + n; r++) begin
      for (int c = 0; c < LPX; c++) begin
        bus.de   = 1'b1;
        bus.gray = 8'(img[r][c]);
        tick();
      end
      bus.de   = 1'b0;
      bus.gray = 8'($urandom_range(0, 255));
      repeat (GAP) tick();
    end
  endtask

  task automatic run_frame(input int pat, input int md, input int mask);
    gen_img(pat);
    vs_pulse(md);
    push_exp(md, mask);
    drive_lines(0, NLN);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 300 && q.size() != 0; i++) tick();
    check("drain_left", q.size(), 0);
    repeat (3) tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int fd0;
    int waited;
    rstn = 1'b0;
    bus.vs = 1'b0; bus.de = 1'b0; bus.gray = '0; bus.mode = '0; bus.out_ready = 1'b1;
    repeat (3) tick();
    check("rst_stat", bus.stat, 0);
    check("rst_valid", bus.stat_valid, 0);
    check("rst_bx", bus.stat_bx, 0);
    check("rst_by", bus.stat_by, 0);
    check("rst_fd", bus.frame_done, 0);
    check("rst_ovf", bus.ovf, 0);
    rstn = 1'b1;
    repeat (2) tick();

    // Fixed patterns, then random images in every mode including reserved 3.
    fd0 = fd_cnt;
    run_frame(0, 0, 3); wait_drain();
    check("fd_one_frame", fd_cnt - fd0, 1);
    run_frame(1, 1, 3); wait_drain();
    run_frame(1, 2, 3); wait_drain();
    run_frame(2, 0, 3); wait_drain();
    for (int m = 0; m < 4; m++) begin run_frame(3, m, 3); wait_drain(); end
    check("fd_count", fd_cnt - fd0, 8);
    check("no_ovf", bus.ovf, 0);

    // Back-pressure for 5 cycles in the middle of a drain.
    gen_img(3); vs_pulse(0); push_exp(0, 3);
    fork
      drive_lines(0, NLN);
      begin
        waited = 0;
        while (!bus.stat_valid && waited < 400) begin tick(); waited++; end
        check("stall_wait_timeout", int'(waited >= 400), 0);
        tick();
        bus.out_ready = 1'b0;
        repeat (5) tick();
        bus.out_ready = 1'b1;
      end
    join
    wait_drain();

    // Two rows complete while blocked: second row dropped, ovf sticky until vs.
    bus.out_ready = 1'b0;
    fd0 = fd_cnt;
    gen_img(3); vs_pulse(1); push_exp(1, 1); drive_lines(0, NLN);
    check("ovf_set", bus.ovf, 1);
    check("ovf_valid", bus.stat_valid, 1);
    check("ovf_by", bus.stat_by, 0);
    bus.out_ready = 1'b1;
    wait_drain();
    check("ovf_no_fd", fd_cnt - fd0, 0);
    check("ovf_sticky", bus.ovf, 1);
    vs_pulse(0);
    check("ovf_clear", bus.ovf, 0);

    // vs rise during a drain aborts it.
    bus.out_ready = 1'b0;
    gen_img(3); vs_pulse(0); drive_lines(0, BH);
    check("abort_pre_valid", bus.stat_valid, 1);
    fd0 = fd_cnt;
    bus.vs = 1'b1;
    tick();
    check("abort_valid", bus.stat_valid, 0);
    bus.vs = 1'b0;
    bus.out_ready = 1'b1;
    repeat (20) tick();
    check("abort_idle", bus.stat_valid, 0);
    check("abort_no_fd", fd_cnt - fd0, 0);
    run_frame(3, 2, 3); wait_drain();

    // Reset in the middle of a drain, then the rest of the frame must be silent.
    bus.out_ready = 1'b0;
    gen_img(3); vs_pulse(0); drive_lines(0, BH + 1);
    check("mrst_pre_valid", bus.stat_valid, 1);
    rstn = 1'b0;
    tick();
    check("mrst_valid", bus.stat_valid, 0);
    check("mrst_stat", bus.stat, 0);
    check("mrst_bx", bus.stat_bx, 0);
    check("mrst_by", bus.stat_by, 0);
    check("mrst_ovf", bus.ovf, 0);
    bus.out_ready = 1'b1;
    tick();
    rstn = 1'b1;
    drive_lines(BH + 1, NLN - BH - 1);
    check("mrst_silent", bus.stat_valid, 0);
    fd0 = fd_cnt;
    run_frame(3, 1, 3); wait_drain();
    check("mrst_fd", fd_cnt - fd0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
